// File: rtl/pump_scheduler.sv
// pump_scheduler: round-robin timed-pour sequencer for N_PUMPS motors sharing one PWM'd enable.
// Define PUMP_SOFTSTART_EN to ramp the PWM duty from 1 up to DUTY, one step per tick.
module pump_slot #(
  parameter int DUR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [DUR_W-1:0] dur,
  input  logic             abort,
  input  logic             granted,
  input  logic             clr,
  output logic             pending,
  output logic             pending_nxt,
  output logic [DUR_W-1:0] dur_lat
);
  logic set;

  // A pending duration is never overwritten, and the running pump cannot queue itself again.
  assign set = req && (dur != '0) && !pending && !granted && !abort;

  always_comb begin
    pending_nxt = pending;
    if (abort || clr) pending_nxt = 1'b0;
    else if (set)     pending_nxt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      dur_lat <= '0;
    end else begin
      pending <= pending_nxt;
      if (set) dur_lat <= dur;
    end
  end
endmodule

module pump_scheduler #(
  parameter int N_PUMPS  = 4,
  parameter int DUR_W    = 8,
  parameter int TICK_CYC = 50000,
  parameter int DEAD_CYC = 1000,
  parameter int PWM_W    = 4,
  parameter int DUTY     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PUMPS-1:0]       req,
  input  logic [N_PUMPS*DUR_W-1:0] dur,
  input  logic                     abort,
  output logic [N_PUMPS-1:0]       in1,
  output logic                     enA,
  output logic                     busy,
  output logic                     done,
  output logic [2:0]               active_id
);
  localparam int IDW = (N_PUMPS > 1) ? $clog2(N_PUMPS) : 1;
  localparam int TW  = $clog2(TICK_CYC);
  localparam int GW  = $clog2(DEAD_CYC + 1);
  localparam int DTW = PWM_W + 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CYC - 1);
  localparam logic [GW-1:0]  GAP_LAST  = GW'(DEAD_CYC - 1);
  localparam logic [DTW-1:0] DUTY_MAX  = DTW'(DUTY);
`ifdef PUMP_SOFTSTART_EN
  localparam logic [DTW-1:0] DUTY_START = (DUTY >= 1) ? DTW'(1) : DTW'(0);
`endif

  typedef enum logic [1:0] {IDLE, GAP, RUN} state_t;

  state_t                        state, nxt_state;
  logic [2:0]                    rr_ptr, nxt_rr, nxt_act;
  logic [DUR_W-1:0]              dur_left, nxt_dur_left;
  logic [TW-1:0]                 tick, nxt_tick;
  logic [GW-1:0]                 gap_cnt, nxt_gap;
  logic [PWM_W-1:0]              pwm_cnt, nxt_pwm;
  logic [DTW-1:0]                duty_eff, nxt_duty;
  logic [N_PUMPS-1:0]            pending, nxt_pending, granted, clr;
  logic [N_PUMPS-1:0][DUR_W-1:0] dur_lat;
  logic                          found;
  logic [IDW-1:0]                pick;

  for (genvar k = 0; k < N_PUMPS; k++) begin : g_slot
    assign granted[k] = (state != IDLE) && (active_id == 3'(k));
    pump_slot #(.DUR_W(DUR_W)) u_slot (
      .clk         (clk),
      .rst         (rst),
      .req         (req[k]),
      .dur         (dur[k*DUR_W +: DUR_W]),
      .abort       (abort),
      .granted     (granted[k]),
      .clr         (clr[k]),
      .pending     (pending[k]),
      .pending_nxt (nxt_pending[k]),
      .dur_lat     (dur_lat[k])
    );
  end

  function automatic logic [IDW-1:0] rot_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_PUMPS) s = s - N_PUMPS;
    return IDW'(s);
  endfunction

  function automatic logic [2:0] inc_wrap(input logic [IDW-1:0] p);
    return (int'(p) == N_PUMPS - 1) ? 3'd0 : 3'(int'(p) + 1);
  endfunction

  // First pending pump at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < N_PUMPS; i++) begin
      if (!found && pending[rot_idx(rr_ptr, i)]) begin
        found = 1'b1;
        pick  = rot_idx(rr_ptr, i);
      end
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_rr       = rr_ptr;
    nxt_act      = active_id;
    nxt_dur_left = dur_left;
    nxt_tick     = tick;
    nxt_gap      = gap_cnt;
    nxt_pwm      = pwm_cnt;
    nxt_duty     = duty_eff;
    clr          = '0;
    if (abort) begin
      nxt_state = IDLE;
    end else begin
      case (state)
        IDLE: if (found) begin
          nxt_state    = GAP;
          nxt_act      = 3'(pick);
          nxt_rr       = inc_wrap(pick);
          nxt_dur_left = dur_lat[pick];
          nxt_gap      = '0;
          clr          = N_PUMPS'(1) << pick;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            nxt_state = RUN;
            nxt_tick  = '0;
            nxt_pwm   = '0;
`ifdef PUMP_SOFTSTART_EN
            nxt_duty  = DUTY_START;
`else
            nxt_duty  = DUTY_MAX;
`endif
          end else begin
            nxt_gap = gap_cnt + GW'(1);
          end
        end
        RUN: begin
          nxt_pwm = pwm_cnt + PWM_W'(1);
          if (tick == TICK_LAST) begin
            nxt_tick     = '0;
            nxt_dur_left = dur_left - DUR_W'(1);
            if (dur_left == DUR_W'(1)) nxt_state = IDLE;
`ifdef PUMP_SOFTSTART_EN
            if (duty_eff < DUTY_MAX) nxt_duty = duty_eff + DTW'(1);
`endif
          end else begin
            nxt_tick = tick + TW'(1);
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      dur_left  <= '0;
      tick      <= '0;
      gap_cnt   <= '0;
      pwm_cnt   <= '0;
      duty_eff  <= '0;
      in1       <= '0;
      enA       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      active_id <= '0;
    end else begin
      state     <= nxt_state;
      rr_ptr    <= nxt_rr;
      dur_left  <= nxt_dur_left;
      tick      <= nxt_tick;
      gap_cnt   <= nxt_gap;
      pwm_cnt   <= nxt_pwm;
      duty_eff  <= nxt_duty;
      in1       <= (nxt_state == RUN) ? (N_PUMPS'(1) << nxt_act) : '0;
      enA       <= (nxt_state == RUN) && ({1'b0, nxt_pwm} < nxt_duty);
      done      <= (nxt_state == RUN) && (nxt_tick == TICK_LAST) && (nxt_dur_left == DUR_W'(1));
      busy      <= (nxt_state != IDLE) || (|nxt_pending);
      active_id <= (nxt_state != IDLE) ? nxt_act : 3'd0;
    end
  end
endmodule
